// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer.
// The head entry drives mem_* directly from flops. The skid entry catches
// one extra bundle when MEM stalls. A saturating counter records stall
// cycles.
module ex_mem_pipe_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_mem_write,
   input  logic              ex_reg_write,
   input  logic              flush,
   input  logic              mem_ready,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_result,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_store_data,
   output logic [REG_W-1:0]  mem_rd,
   output logic              mem_mem_write,
   output logic              mem_reg_write,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_count
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] store_data;
      logic [REG_W-1:0]  rd;
      logic              mem_write;
      logic              reg_write;
   } payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   payload_t          head_q, head_d;
   payload_t          skid_q, skid_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   payload_t          ex_pl;
   logic              accept;
   logic              deliver;

   // Handshake flags derived straight from the state flop
   assign ex_ready  = (state_q != FULL);
   assign mem_valid = (state_q != EMPTY);
   assign occupancy = 2'(state_q);
   assign accept    = ex_valid && ex_ready;
   assign deliver   = mem_valid && mem_ready;

   assign ex_pl = '{result:     ex_result,
                    addr:       ex_addr,
                    store_data: ex_store_data,
                    rd:         ex_rd,
                    mem_write:  ex_mem_write,
                    reg_write:  ex_reg_write};

   // Next-state, payload movement and stall counter
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      stall_d = stall_q;

      if (flush) begin
         // Kill only the side-effect flags so a killed head can do no harm
         state_d          = EMPTY;
         head_d.mem_write = 1'b0;
         head_d.reg_write = 1'b0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  head_d  = ex_pl;
               end
            end
            ONE: begin
               if (accept && deliver) begin
                  head_d = ex_pl;
               end else if (accept) begin
                  state_d = FULL;
                  skid_d  = ex_pl;
               end else if (deliver) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (deliver) begin
                  state_d = ONE;
                  head_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      if (mem_valid && !mem_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   // State and payload registers with asynchronous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end

   assign mem_result     = head_q.result;
   assign mem_addr       = head_q.addr;
   assign mem_store_data = head_q.store_data;
   assign mem_rd         = head_q.rd;
   assign mem_mem_write  = head_q.mem_write;
   assign mem_reg_write  = head_q.reg_write;
   assign stall_count    = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: a vector table for the handshake
// and flush behaviour, plus sequences for saturation and async reset.
module tb_ex_mem_pipe_reg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              ex_valid;
   logic              ex_ready;
   logic [DATA_W-1:0] ex_result;
   logic [ADDR_W-1:0] ex_addr;
   logic [DATA_W-1:0] ex_store_data;
   logic [REG_W-1:0]  ex_rd;
   logic              ex_mem_write;
   logic              ex_reg_write;
   logic              flush;
   logic              mem_ready;
   logic              mem_valid;
   logic [DATA_W-1:0] mem_result;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_store_data;
   logic [REG_W-1:0]  mem_rd;
   logic              mem_mem_write;
   logic              mem_reg_write;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_count;

   int checks = 0;
   int errors = 0;

   ex_mem_pipe_reg #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_result(ex_result), .ex_addr(ex_addr),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
      .flush(flush), .mem_ready(mem_ready), .mem_valid(mem_valid),
      .mem_result(mem_result), .mem_addr(mem_addr),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd),
      .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
      .occupancy(occupancy), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   // Hard stop in case something keeps the bench from finishing
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        v;
      logic [31:0] res;
      logic [4:0]  rd;
      logic        mw, rw, fl, mr;
      logic        e_valid, e_ready;
      logic [1:0]  e_occ;
      logic [31:0] e_res;
      logic [4:0]  e_rd;
      logic        e_mw, e_rw;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   // Address and store data derived differently from the result so swapped fields show up
   function automatic logic [31:0] addr_of(input logic [31:0] r);
      return r ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] sd_of(input logic [31:0] r);
      return r + 32'h0100_0000;
   endfunction

   function automatic vec_t mk(input logic v, input logic [31:0] res, input logic [4:0] rd,
                               input logic mw, input logic rw, input logic fl, input logic mr,
                               input logic e_valid, input logic e_ready, input logic [1:0] e_occ,
                               input logic [31:0] e_res, input logic [4:0] e_rd,
                               input logic e_mw, input logic e_rw);
      vec_t t;
      t.v = v; t.res = res; t.rd = rd; t.mw = mw; t.rw = rw; t.fl = fl; t.mr = mr;
      t.e_valid = e_valid; t.e_ready = e_ready; t.e_occ = e_occ;
      t.e_res = e_res; t.e_rd = e_rd; t.e_mw = e_mw; t.e_rw = e_rw;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                        input logic mw, input logic rw, input logic fl, input logic mr);
      ex_valid      = v;
      ex_result     = res;
      ex_addr       = addr_of(res);
      ex_store_data = sd_of(res);
      ex_rd         = rd;
      ex_mem_write  = mw;
      ex_reg_write  = rw;
      flush         = fl;
      mem_ready     = mr;
   endtask

   task automatic do_reset();
      @(negedge clock);
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // One clocked step: drive on the falling edge, let the rising edge act
   task automatic step(input logic v, input logic [31:0] res, input logic [4:0] rd,
                       input logic mw, input logic rw, input logic fl, input logic mr);
      @(negedge clock);
      drive(v, res, rd, mw, rw, fl, mr);
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " mem_valid"}, 32'(mem_valid), 32'd0);
      check({tag, " ex_ready"},  32'(ex_ready),  32'd1);
      check({tag, " occupancy"}, 32'(occupancy), 32'd0);
      check({tag, " result"},    mem_result,     32'd0);
      check({tag, " addr"},      mem_addr,       32'd0);
      check({tag, " store"},     mem_store_data, 32'd0);
      check({tag, " rd"},        32'(mem_rd),    32'd0);
      check({tag, " mem_write"}, 32'(mem_mem_write), 32'd0);
      check({tag, " reg_write"}, 32'(mem_reg_write), 32'd0);
      check({tag, " stall"},     32'(stall_count),   32'd0);
   endtask

   // Flushed bundles must never surface as a valid head
   always @(negedge clock) begin
      if (!reset && mem_valid && (mem_result == 32'h99 || mem_result == 32'h32 || mem_result == 32'h41)) begin
         checks++;
         errors++;
         $display("FAIL flushed_visible: got result 0x%0h want none of 99/32/41", mem_result);
      end
   end

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      //            v   res     rd   mw rw fl mr | val rdy occ e_res  e_rd mw rw
      vecs[0]  = mk(1, 32'h11, 5'd3, 0, 1, 0, 1,   1,  1,  1, 32'h11, 5'd3, 0, 1);
      vecs[1]  = mk(0, 32'h00, 5'd0, 0, 0, 0, 1,   0,  1,  0, 32'h11, 5'd3, 0, 1);
      vecs[2]  = mk(1, 32'hA1, 5'd5, 1, 0, 0, 0,   1,  1,  1, 32'hA1, 5'd5, 1, 0);
      vecs[3]  = mk(1, 32'hB2, 5'd6, 0, 1, 0, 0,   1,  0,  2, 32'hA1, 5'd5, 1, 0);
      vecs[4]  = mk(1, 32'hC3, 5'd7, 1, 1, 0, 0,   1,  0,  2, 32'hA1, 5'd5, 1, 0);
      vecs[5]  = mk(0, 32'h00, 5'd0, 0, 0, 0, 1,   1,  1,  1, 32'hB2, 5'd6, 0, 1);
      vecs[6]  = mk(0, 32'h00, 5'd0, 0, 0, 0, 1,   0,  1,  0, 32'hB2, 5'd6, 0, 1);
      vecs[7]  = mk(1, 32'h21, 5'd1, 1, 1, 0, 0,   1,  1,  1, 32'h21, 5'd1, 1, 1);
      vecs[8]  = mk(1, 32'h22, 5'd2, 0, 1, 0, 1,   1,  1,  1, 32'h22, 5'd2, 0, 1);
      vecs[9]  = mk(1, 32'h23, 5'd3, 1, 0, 0, 0,   1,  0,  2, 32'h22, 5'd2, 0, 1);
      vecs[10] = mk(1, 32'h99, 5'd9, 1, 1, 1, 0,   0,  1,  0, 32'h22, 5'd2, 0, 0);
      vecs[11] = mk(0, 32'h00, 5'd0, 0, 0, 0, 1,   0,  1,  0, 32'h22, 5'd2, 0, 0);
      vecs[12] = mk(1, 32'h31, 5'd4, 1, 1, 0, 0,   1,  1,  1, 32'h31, 5'd4, 1, 1);
      vecs[13] = mk(1, 32'h32, 5'd5, 1, 1, 1, 1,   0,  1,  0, 32'h31, 5'd4, 0, 0);
      vecs[14] = mk(1, 32'h41, 5'd6, 1, 1, 1, 0,   0,  1,  0, 32'h31, 5'd4, 0, 0);
      vecs[15] = mk(1, 32'h42, 5'd8, 0, 1, 0, 1,   1,  1,  1, 32'h42, 5'd8, 0, 1);
      vecs[16] = mk(0, 32'h00, 5'd0, 0, 0, 0, 1,   0,  1,  0, 32'h42, 5'd8, 0, 1);

      // Reset values while reset is held
      #12;
      check_idle("reset");
      do_reset();
      check_idle("post_reset");

      // Table-driven handshake, ordering and flush vectors
      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].v, vecs[i].res, vecs[i].rd, vecs[i].mw, vecs[i].rw, vecs[i].fl, vecs[i].mr);
         check($sformatf("v%0d mem_valid", i), 32'(mem_valid),     32'(vecs[i].e_valid));
         check($sformatf("v%0d ex_ready", i),  32'(ex_ready),      32'(vecs[i].e_ready));
         check($sformatf("v%0d occupancy", i), 32'(occupancy),     32'(vecs[i].e_occ));
         check($sformatf("v%0d result", i),    mem_result,         vecs[i].e_res);
         check($sformatf("v%0d addr", i),      mem_addr,           addr_of(vecs[i].e_res));
         check($sformatf("v%0d store", i),     mem_store_data,     sd_of(vecs[i].e_res));
         check($sformatf("v%0d rd", i),        32'(mem_rd),        32'(vecs[i].e_rd));
         check($sformatf("v%0d mem_write", i), 32'(mem_mem_write), 32'(vecs[i].e_mw));
         check($sformatf("v%0d reg_write", i), 32'(mem_reg_write), 32'(vecs[i].e_rw));
      end

      // Stall counter: flush cycles do not count, saturation at 15 without wrap
      do_reset();
      step(1'b1, 32'h55, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      check("stall_after_accept", 32'(stall_count), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("stall_pre_%0d", k), 32'(stall_count), 32'(k));
      end
      step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("stall_flush_hold", 32'(stall_count), 32'd3);
      check("stall_flush_occ",  32'(occupancy),   32'd0);
      step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("stall_empty_hold", 32'(stall_count), 32'd3);
      step(1'b1, 32'h66, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      check("stall_reaccept", 32'(stall_count), 32'd3);
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("stall_sat_%0d", k), 32'(stall_count), (3 + k > 15) ? 32'd15 : 32'(3 + k));
      end
      check("stall_head_stable", mem_result, 32'h66);

      // Asynchronous reset mid-cycle while full
      do_reset();
      step(1'b1, 32'h71, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h72, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      check("async_pre_occ", 32'(occupancy), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      check_idle("async");
      @(negedge clock);
      reset = 1'b0;
      drive(1'b1, 32'h81, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      check("first_accept_occ",    32'(occupancy), 32'd1);
      check("first_accept_result", mem_result,     32'h81);
      check("first_accept_rd",     32'(mem_rd),    32'd7);
      step(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("skid_cleared_occ", 32'(occupancy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_pipe_reg.md
EX_MEM_PIPE_REG -- requirements
Module: ex_mem_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the ALU result and the store data.
REQ-002 SHALL have parameter ADDR_W, default 32: width of the memory address.
REQ-003 SHALL have parameter REG_W, default 5: width of the destination-register index.
REQ-004 SHALL have parameter CNT_W, default 16: width of the stall counter.
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port ex_valid, input, 1: the EX stage presents a valid bundle.
REQ-008 SHALL have port ex_ready, output, 1: the block can accept a bundle this cycle.
REQ-009 SHALL have ports ex_result (DATA_W), ex_addr (ADDR_W), ex_store_data (DATA_W) and ex_rd (REG_W), all inputs: EX payload.
REQ-010 SHALL have ports ex_mem_write and ex_reg_write, inputs, 1 bit each: EX control payload.
REQ-011 SHALL have port flush, input, 1: synchronous pipeline kill.
REQ-012 SHALL have port mem_ready, input, 1: the MEM stage consumes the head bundle this cycle.
REQ-013 SHALL have port mem_valid, output, 1: the head bundle is valid.
REQ-014 SHALL have output ports mem_result, mem_addr, mem_store_data, mem_rd, mem_mem_write and mem_reg_write, each the width of its ex_ counterpart: registered head payload.
REQ-015 SHALL have port occupancy, output, 2: number of bundles held (0..2).
REQ-016 SHALL have port stall_count, output, CNT_W: count of backpressure cycles.

Function
REQ-017 SHALL hold two payload entries: the head, which drives the mem_* outputs directly from flops, and a skid entry.
REQ-018 SHALL define accept as ex_valid && ex_ready, and deliver as mem_valid && mem_ready.
REQ-019 SHALL drive ex_ready = (occupancy != 2).
REQ-020 SHALL drive mem_valid = (occupancy != 0).
REQ-021 SHALL implement states EMPTY (0), ONE (1) and FULL (2); occupancy equals the state encoding.
REQ-022 SHALL, in EMPTY, move to ONE on accept, with head <= ex payload.
REQ-023 SHALL, in ONE, move to FULL on accept without deliver, with skid <= ex payload.
REQ-024 SHALL, in ONE, stay in ONE on accept with deliver, with head <= ex payload.
REQ-025 SHALL, in ONE, move to EMPTY on deliver without accept.
REQ-026 SHALL, in FULL, move to ONE on deliver, with head <= skid; accept cannot occur in FULL.
REQ-027 SHALL otherwise hold state and payload unchanged; mem_* outputs SHALL be stable while mem_valid && !mem_ready.
REQ-028 SHALL have 1-cycle latency: a bundle accepted in EMPTY appears on mem_* with mem_valid=1 in the next cycle.
REQ-029 SHALL preserve strict FIFO order, never duplicate a bundle, and never drop a bundle except on flush.
REQ-030 SHALL give flush priority over accept and deliver: next state EMPTY, mem_mem_write and mem_reg_write cleared to 0, and the ex bundle of that cycle discarded.
REQ-031 SHALL leave the other payload flops unchanged on flush.
REQ-032 SHALL increment stall_count by 1 in every cycle where mem_valid && !mem_ready && !flush.
REQ-033 SHALL saturate stall_count at all-ones with no wrap, and clear it only on reset.
REQ-034 SHALL pass every payload field through bit-exact with no width conversion; ex_addr and ex_store_data are independent fields.

Reset
REQ-035 SHALL, while reset=1 and asynchronously, set state EMPTY, all mem_* payload outputs 0, stall_count 0 and skid 0; therefore mem_valid=0, ex_ready=1 and occupancy=0.
REQ-036 SHALL let reset asserted mid-operation discard all held bundles immediately.
REQ-037 SHALL make the first accept possible on the first rising edge after reset deasserts.

Verification
REQ-038 Scenario: mem_ready=1; ex_valid=1 with ex_result=0x11, ex_rd=3 -> next cycle mem_valid=1, mem_result=0x11, mem_rd=3, occupancy=1.
REQ-039 Scenario: mem_ready=0; bundles A and B sent on consecutive cycles -> occupancy=2, ex_ready=0, mem_* shows A; mem_ready=1 -> A out, then B out, then occupancy=0.
REQ-040 Scenario: occupancy=1, accept and deliver in the same cycle -> occupancy stays 1 and head holds the new bundle.
REQ-041 Scenario: occupancy=2 and flush=1 with ex_valid=1 -> next cycle occupancy=0, mem_valid=0, mem_reg_write=0, mem_mem_write=0, and the incoming bundle is never seen.
REQ-042 Scenario: CNT_W=4, head held with mem_ready=0 for 20 cycles -> stall_count reaches 15 and holds at 15.
REQ-043 Scenario: reset pulsed asynchronously mid-cycle at occupancy=2 -> outputs are 0, occupancy=0 and ex_ready=1 before the next clock edge.
